// File: rtl/paper_processor_gen.sv
// Parametrised paper-computer counter machine: program RAM, NUM_REGS counters,
// and a FETCH/EXEC sequencer running INC/DEC/CLR/JMP/JZ/HALT with an illegal-op trap.
module paper_processor_gen #(
  parameter  int REG_W    = 8,
  parameter  int NUM_REGS = 4,
  parameter  int PC_W     = 4,
  localparam int RSEL_W   = $clog2(NUM_REGS),
  localparam int INSTR_W  = 3 + RSEL_W + PC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               reg_we,
  input  logic [RSEL_W-1:0]  reg_sel,
  input  logic [REG_W-1:0]   reg_wdata,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [REG_W-1:0]   dbg_data,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]         state,
  output logic [INSTR_W-1:0] instr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               ovf
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_HALT = 3'd0,
    OP_INC  = 3'd1,
    OP_DEC  = 3'd2,
    OP_JMP  = 3'd3,
    OP_JZ   = 3'd4,
    OP_CLR  = 3'd5
  } op_e;

  localparam logic [RSEL_W:0] NUM_REGS_W = (RSEL_W + 1)'(NUM_REGS);

  function automatic logic rsel_ok(input logic [RSEL_W-1:0] s);
    return {1'b0, s} < NUM_REGS_W;
  endfunction

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic [REG_W-1:0]   regs_q [NUM_REGS];
  logic [INSTR_W-1:0] ram_q [2**PC_W];

  logic [2:0]         op;
  logic [RSEL_W-1:0]  rsel;
  logic [PC_W-1:0]    addr;
  logic [REG_W-1:0]   cur_val;
  logic [PC_W-1:0]    pc_inc;
  logic               exec_we;
  logic [REG_W-1:0]   exec_val;
  logic               load_we;

  assign op      = instr_q[INSTR_W-1 -: 3];
  assign rsel    = instr_q[PC_W +: RSEL_W];
  assign addr    = instr_q[PC_W-1:0];
  assign cur_val = rsel_ok(rsel) ? regs_q[rsel] : '0;
  assign pc_inc  = pc_q + 1'b1;

  assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign load_we = reg_we && !busy && rsel_ok(reg_sel);

  // NOTE: program RAM has no reset so it survives a mid-run abort and maps onto plain memory.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) ram_q[prog_addr] <= prog_wdata;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    done_d   = done_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    exec_we  = 1'b0;
    exec_val = cur_val;
    if (clk_en) begin
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        S_FETCH: begin
          instr_d = ram_q[pc_q];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          case (op_e'(op))
            OP_HALT: begin
              done_d  = 1'b1;
              state_d = S_HALTED;
            end
            OP_INC: begin
              exec_we  = rsel_ok(rsel);
              exec_val = cur_val + 1'b1;
              if (&cur_val) ovf_d = 1'b1;
              pc_d     = pc_inc;
            end
            OP_DEC: begin
              // Floors at zero without raising any flag.
              exec_we  = rsel_ok(rsel) && (cur_val != '0);
              exec_val = cur_val - 1'b1;
              pc_d     = pc_inc;
            end
            OP_JMP: pc_d = addr;
            OP_JZ:  pc_d = (cur_val == '0) ? addr : pc_inc;
            OP_CLR: begin
              exec_we  = rsel_ok(rsel);
              exec_val = '0;
              pc_d     = pc_inc;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_HALTED;
            end
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      // Exec and preload never collide: exec only happens while busy.
      if (exec_we)      regs_q[rsel]    <= exec_val;
      else if (load_we) regs_q[reg_sel] <= reg_wdata;
    end
  end

  assign dbg_data = rsel_ok(dbg_sel) ? regs_q[dbg_sel] : '0;
  assign pc       = pc_q;
  assign state    = state_q;
  assign instr    = instr_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ovf      = ovf_q;

endmodule
